monitor_aleatorio: RTL and testbench

- Consumer end of the random-generator interface: samples `gerador_aleatorio_32` output words and builds a per-value histogram in hardware.
- Stops when any bin exceeds a threshold, then exposes bin counts through a synchronous read port for display/debug.
- Sits beside the generator in the pet-event logic; used on-board to check uniformity before random events are trusted.

---
 rtl/aleatorio_pkg.sv | 21 ++
 rtl/hist_ram.sv | 36 +++
 rtl/monitor_aleatorio.sv | 201 ++++++++++++++++++++
 tb/tb_monitor_aleatorio.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/aleatorio_pkg.sv
// Shared types and default sizing for the random-sample histogram monitor.
package aleatorio_pkg;

  localparam int unsigned DEF_WIDTH     = 3;
  localparam int unsigned DEF_CNT_W     = 8;
  localparam int unsigned DEF_THRESHOLD = 100;
  localparam int unsigned DEF_TOT_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_COUNT = 3'd2,
    ST_SCAN  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic int unsigned nbins(input int unsigned width);
    return 32'd1 << width;
  endfunction

endpackage

// File: rtl/hist_ram.sv
// Histogram storage: one write port, one registered read port with
// same-address write-to-read bypass so back-to-back updates see fresh data.
module hist_ram
  import aleatorio_pkg::*;
#(
  parameter int unsigned AW = DEF_WIDTH,
  parameter int unsigned DW = DEF_CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = nbins(AW);

  logic [DW-1:0] mem [DEPTH];

  // Contents are left unreset; the monitor clears every bin before counting.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/monitor_aleatorio.sv
// Histogram monitor for the random generator: clear, count until a bin
// exceeds THRESHOLD, then serve bin reads. MONITOR_ALEATORIO_SPREAD_EN adds a
// SCAN pass that reports the minimum and maximum bin counts.
module monitor_aleatorio
  import aleatorio_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned THRESHOLD = DEF_THRESHOLD,
  parameter int unsigned TOT_W     = DEF_TOT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hit_bin,
  output logic [TOT_W-1:0] total,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_data,
`ifdef MONITOR_ALEATORIO_SPREAD_EN
  output logic [CNT_W-1:0] bin_min,
  output logic [CNT_W-1:0] bin_max,
`endif
  output logic             rd_valid
);

  localparam int unsigned NBINS = nbins(WIDTH);
  localparam logic [WIDTH-1:0] LAST_BIN = WIDTH'(NBINS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ptr_q, ptr_d;
  logic [TOT_W-1:0] total_d;
  logic [WIDTH-1:0] hit_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_idx_q, s1_idx_d;
  logic             rd_valid_d;
  logic [CNT_W-1:0] rd_hold_q;
  logic             busy_d, done_d;

  logic             ram_we, ram_re;
  logic [WIDTH-1:0] ram_waddr, ram_raddr;
  logic [CNT_W-1:0] ram_wdata, ram_rdata;
  logic [CNT_W-1:0] inc;

`ifdef MONITOR_ALEATORIO_SPREAD_EN
  logic [CNT_W-1:0] min_d, max_d;
`endif

  hist_ram #(.AW(WIDTH), .DW(CNT_W)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Read data comes straight from the RAM register on a read pulse, else holds.
  assign rd_data = rd_valid ? ram_rdata : rd_hold_q;

  // Sample pipeline: stage 0 issues the bin read, stage 1 writes bin+1.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    total_d    = total;
    hit_d      = hit_bin;
    s1_valid_d = 1'b0;
    s1_idx_d   = s1_idx_q;
    rd_valid_d = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = ptr_q;
    ram_wdata  = '0;
    ram_re     = 1'b0;
    ram_raddr  = data_in;
    inc        = ram_rdata + CNT_W'(1);
`ifdef MONITOR_ALEATORIO_SPREAD_EN
    min_d      = bin_min;
    max_d      = bin_max;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
          total_d = '0;
        end
      end

      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = ptr_q;
        ptr_d     = ptr_q + WIDTH'(1);
        if (ptr_q == LAST_BIN) state_d = ST_COUNT;
      end

      ST_COUNT: begin
        if (data_valid) begin
          ram_re     = 1'b1;
          ram_raddr  = data_in;
          s1_valid_d = 1'b1;
          s1_idx_d   = data_in;
        end
        if (s1_valid_q) begin
          ram_we    = 1'b1;
          ram_waddr = s1_idx_q;
          ram_wdata = inc;
          if (total != '1) total_d = total + TOT_W'(1);
          if (inc > CNT_W'(THRESHOLD)) begin
            hit_d      = s1_idx_q;
            s1_valid_d = 1'b0;
`ifdef MONITOR_ALEATORIO_SPREAD_EN
            // Redirect the read port to bin 0 so SCAN sees it on its first cycle.
            state_d   = ST_SCAN;
            ptr_d     = '0;
            ram_re    = 1'b1;
            ram_raddr = '0;
`else
            state_d   = ST_DONE;
`endif
          end
        end
      end

`ifdef MONITOR_ALEATORIO_SPREAD_EN
      ST_SCAN: begin
        ram_re    = 1'b1;
        ram_raddr = ptr_q + WIDTH'(1);
        ptr_d     = ptr_q + WIDTH'(1);
        if (ptr_q == '0) begin
          min_d = ram_rdata;
          max_d = ram_rdata;
        end else begin
          if (ram_rdata < bin_min) min_d = ram_rdata;
          if (ram_rdata > bin_max) max_d = ram_rdata;
        end
        if (ptr_q == LAST_BIN) state_d = ST_DONE;
      end
`endif

      ST_DONE: begin
        if (rd_en) begin
          ram_re     = 1'b1;
          ram_raddr  = rd_idx;
          rd_valid_d = 1'b1;
        end
        if (start) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
          total_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_CLEAR) || (state_d == ST_COUNT) || (state_d == ST_SCAN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      total      <= '0;
      hit_bin    <= '0;
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      rd_valid   <= 1'b0;
      rd_hold_q  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef MONITOR_ALEATORIO_SPREAD_EN
      bin_min    <= '0;
      bin_max    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      total      <= total_d;
      hit_bin    <= hit_d;
      s1_valid_q <= s1_valid_d;
      s1_idx_q   <= s1_idx_d;
      rd_valid   <= rd_valid_d;
      rd_hold_q  <= rd_data;
      busy       <= busy_d;
      done       <= done_d;
`ifdef MONITOR_ALEATORIO_SPREAD_EN
      bin_min    <= min_d;
      bin_max    <= max_d;
`endif
    end
  end

endmodule

// File: tb/tb_monitor_aleatorio.sv
// Directed bench for monitor_aleatorio; bin reads are checked through a
// scoreboard queue. Covers the SCAN path when MONITOR_ALEATORIO_SPREAD_EN is set.
module tb_monitor_aleatorio;

`ifdef MONITOR_ALEATORIO_SPREAD_EN
  localparam int SCAN_CYC = 8;
`else
  localparam int SCAN_CYC = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] data_in;
  logic       data_valid;
  logic       busy;
  logic       done;
  logic [2:0] hit_bin;
  logic [15:0] total;
  logic       rd_en;
  logic [2:0] rd_idx;
  logic [7:0] rd_data;
  logic       rd_valid;
`ifdef MONITOR_ALEATORIO_SPREAD_EN
  logic [7:0] bin_min;
  logic [7:0] bin_max;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] sb [$];

  monitor_aleatorio dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .data_in    (data_in),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done),
    .hit_bin    (hit_bin),
    .total      (total),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
`ifdef MONITOR_ALEATORIO_SPREAD_EN
    .bin_min    (bin_min),
    .bin_max    (bin_max),
`endif
    .rd_valid   (rd_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [2:0] idx, input logic [7:0] exp);
    rd_en  = 1'b1;
    rd_idx = idx;
    sb.push_back(exp);
    tick();
    check("rd_valid_pulse", 32'(rd_valid), 32'd1);
  endtask

  task automatic end_reads();
    rd_en = 1'b0;
    tick();
    check("rd_valid_low", 32'(rd_valid), 32'd0);
  endtask

  // Wait for done with a cycle budget; returns cycles spent.
  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (done !== 1'b1) check("done_timeout", 32'(done), 32'd1);
  endtask

  // Scoreboard consumer: every rd_valid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rd_valid", 32'(rd_valid), 32'd0);
      end else begin
        check("rd_data", 32'(rd_data), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    int n;
    int idx;
    rst_n = 1'b0; start = 1'b0; data_in = '0; data_valid = 1'b0;
    rd_en = 1'b0; rd_idx = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hit_bin", 32'(hit_bin), 32'd0);
    check("rst_total", 32'(total), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // Run 1: constant bin 5 from the start pulse onward.
    start = 1'b1; data_valid = 1'b1; data_in = 3'd5;
    tick();
    start = 1'b0;
    check("clear_busy", 32'(busy), 32'd1);
    n = 1;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
      if (n == 10) check("clear_len_total0", 32'(total), 32'd0);
      if (n == 11) check("first_count_total1", 32'(total), 32'd1);
    end
    data_valid = 1'b0;
    check("run1_done_cycle", 32'(n), 32'(111 + SCAN_CYC));
    check("run1_hit_bin", 32'(hit_bin), 32'd5);
    check("run1_total", 32'(total), 32'd101);
    check("run1_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 8; k++) do_read(3'(k), (k == 5) ? 8'd101 : 8'd0);
    do_read(3'd5, 8'd101);
    end_reads();
    check("rd_data_hold", 32'(rd_data), 32'd101);

    // Run 2: round-robin with data_valid toggling; rd_en held during COUNT.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    rd_en = 1'b1; rd_idx = 3'd0;
    idx = 0;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      data_valid = ~n[0];
      data_in    = 3'(idx);
      if (!n[0]) idx++;
      tick();
      n++;
    end
    rd_en = 1'b0; data_valid = 1'b0;
    check("run2_done", 32'(done), 32'd1);
    check("run2_rd_data_held", 32'(rd_data), 32'd101);
    check("run2_hit_bin", 32'(hit_bin), 32'd0);
    check("run2_total", 32'(total), 32'd801);
    for (int k = 0; k < 8; k++) do_read(3'(k), (k == 0) ? 8'd101 : 8'd100);
    end_reads();

    // Run 3: reset in the middle of COUNT, then a fresh run must reclear.
    start = 1'b1;
    tick();
    start = 1'b0;
    data_valid = 1'b1; data_in = 3'd3;
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_total", 32'(total), 32'd0);
    data_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    data_valid = 1'b1; data_in = 3'd2;
    wait_done(400, n);
    data_valid = 1'b0;
    check("run3_hit_bin", 32'(hit_bin), 32'd2);
    check("run3_total", 32'(total), 32'd101);
    do_read(3'd3, 8'd0);
    do_read(3'd2, 8'd101);
    do_read(3'd7, 8'd0);
    end_reads();

`ifdef MONITOR_ALEATORIO_SPREAD_EN
    // Run 4: bins {101,3,3,3,3,3,3,2}; rd_en held through COUNT and SCAN.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    rd_en = 1'b1; rd_idx = 3'd1;
    for (int b = 1; b < 8; b++) begin
      for (int r = 0; r < ((b == 7) ? 2 : 3); r++) begin
        data_valid = 1'b1; data_in = 3'(b);
        tick();
      end
    end
    data_in = 3'd0;
    n = 0;
    while (total !== 16'd121 && n < 400) begin
      tick();
      n++;
    end
    data_valid = 1'b0;
    check("run4_total", 32'(total), 32'd121);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("scan_done_timing", 32'(done), (i == 8) ? 32'd1 : 32'd0);
    end
    rd_en = 1'b0;
    check("bin_min", 32'(bin_min), 32'd2);
    check("bin_max", 32'(bin_max), 32'd101);
    check("run4_hit_bin", 32'(hit_bin), 32'd0);
    do_read(3'd0, 8'd101);
    do_read(3'd7, 8'd2);
    end_reads();
`endif

    repeat (2) tick();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
